// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer for the frequency meter: gate window, result latch, BCD handshake,
// display hold and re-arm, with selectable gate time and single-shot or continuous operation.
module freq_meter_ctrl #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned HOLD_CYCLES  = 25_000_000,
    parameter int unsigned CONV_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       run,
    input  logic       single,
    input  logic [1:0] range_sel,
    input  logic       cnt_ovf,
    input  logic       bcd_done,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       latch_en,
    output logic       bcd_start,
    output logic       busy,
    output logic       ovf,
    output logic       err,
    output logic [1:0] range_q
);

    localparam int unsigned TW = $clog2(CLK_HZ + 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StLatch,
        StConv,
        StHold
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    range_s_q, range_s_d;
    logic [1:0]    range_out_q, range_out_d;
    logic          sticky_q, sticky_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          conv_first;

    // Last value of the gate down-counter, i.e. gate length minus one.
    function automatic logic [TW-1:0] gate_last(input logic [1:0] r);
        logic [TW-1:0] v;
        case (r)
            2'd0:    v = TW'(CLK_HZ - 1);
            2'd1:    v = TW'(CLK_HZ / 10 - 1);
            2'd2:    v = TW'(CLK_HZ / 100 - 1);
            default: v = TW'(CLK_HZ / 1000 - 1);
        endcase
        return v;
    endfunction

    // The timeout counter is loaded on CONV entry, so its reload value marks the first cycle.
    assign conv_first = (tmr_q == TW'(CONV_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        range_s_d   = range_s_q;
        range_out_d = range_out_q;
        sticky_d    = sticky_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        latch_en    = 1'b0;
        bcd_start   = 1'b0;
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (run || single) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_clr   = 1'b1;
                range_s_d = range_sel;
                sticky_d  = 1'b0;
                tmr_d     = gate_last(range_sel);
                state_d   = StGate;
            end
            StGate: begin
                cnt_en   = 1'b1;
                sticky_d = sticky_q | cnt_ovf;
                if (tmr_q == '0) begin
                    state_d = StLatch;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StLatch: begin
                latch_en    = 1'b1;
                ovf_d       = sticky_q | cnt_ovf;
                range_out_d = range_s_q;
                err_d       = 1'b0;
                tmr_d       = TW'(CONV_TIMEOUT - 1);
                state_d     = StConv;
            end
            StConv: begin
                bcd_start = conv_first;
                if (!conv_first && bcd_done) begin
                    tmr_d   = TW'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    tmr_d   = TW'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            StHold: begin
                if (tmr_q == '0) begin
                    state_d = run ? StClear : StIdle;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a_p) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            range_s_q   <= 2'd0;
            range_out_q <= 2'd0;
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            range_s_q   <= range_s_d;
            range_out_q <= range_out_d;
            sticky_q    <= sticky_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign ovf     = ovf_q;
    assign err     = err_q;
    assign range_q = range_out_q;

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Bench for freq_meter_ctrl: table of single-shot measurements checked through a scoreboard,
// plus hand-written reset, busy-gating and continuous-mode sequences.
module tb_freq_meter_ctrl;

    logic       clk = 1'b0;
    logic       rst_a_p = 1'b1;
    logic       run = 1'b0;
    logic       single = 1'b0;
    logic [1:0] range_sel = 2'd0;
    logic       cnt_ovf = 1'b0;
    logic       bcd_done = 1'b0;
    logic       cnt_clr, cnt_en, latch_en, bcd_start, busy, ovf, err;
    logic [1:0] range_q;

    freq_meter_ctrl #(
        .CLK_HZ      (10_000),
        .HOLD_CYCLES (20),
        .CONV_TIMEOUT(64)
    ) dut (
        .clk      (clk),
        .rst_a_p  (rst_a_p),
        .run      (run),
        .single   (single),
        .range_sel(range_sel),
        .cnt_ovf  (cnt_ovf),
        .bcd_done (bcd_done),
        .cnt_clr  (cnt_clr),
        .cnt_en   (cnt_en),
        .latch_en (latch_en),
        .bcd_start(bcd_start),
        .busy     (busy),
        .ovf      (ovf),
        .err      (err),
        .range_q  (range_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] rng;
        int         dly;     // bcd_done delay after bcd_start, -1 = never
        int         ovf_at;  // gate cycle of a cnt_ovf pulse, -1 = none
        bit         toggle;
        bit         extra;
        int         g;
        int         tail;
        int         ovf;
        int         err;
        int         err_at;
    } vec_t;

    typedef struct {
        int g;
        int lat;
        int tail;
        int ovf;
        int err;
        int rq;
        int err_at;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_dly = -1;
    bit mon_en = 1'b0;

    int gate_w = 0, clr_cyc = 0, bs_cyc = 0, err_at = -1, clr_total = 0, proto_bad = 0;
    bit have_bs = 1'b0, prev_clr = 1'b0, prev_latch = 1'b0, prev_bs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [8:0] v;
        v = {cnt_clr, cnt_en, latch_en, bcd_start, busy, ovf, err, range_q};
        tests++;
        if (v !== 9'b0) begin
            fails++;
            $display("FAIL %s: outputs %b, expected all zero", name, v);
        end
    endtask

    task automatic wait_sig(input int which, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (which == 0 && cnt_en === 1'b1) return;
            if (which == 1 && busy === 1'b0) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: event not seen within %0d cycles, required it", name, budget);
    endtask

    // Monitor: rebuilds one record per measurement and compares it with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if ($countones({cnt_clr, cnt_en, latch_en, bcd_start}) > 1) proto_bad++;
                if ((cnt_clr && prev_clr) || (latch_en && prev_latch) || (bcd_start && prev_bs))
                    proto_bad++;
                prev_clr   = cnt_clr;
                prev_latch = latch_en;
                prev_bs    = bcd_start;
                if (have_bs && (cnt_clr === 1'b1 || busy === 1'b0)) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_measurement: got gate width %0d, expected none",
                                 gate_w);
                    end else begin
                        e = sb.pop_front();
                        check("gate_width", gate_w, e.g);
                        check("clr_to_bcd_start", bs_cyc - clr_cyc, e.lat);
                        check("bcd_start_to_rearm", cyc - bs_cyc, e.tail);
                        check("ovf", int'(ovf), e.ovf);
                        check("err", int'(err), e.err);
                        check("range_q", int'(range_q), e.rq);
                        check("err_delay", err_at, e.err_at);
                    end
                    have_bs = 1'b0;
                end
                if (cnt_clr === 1'b1) begin
                    clr_total++;
                    clr_cyc = cyc;
                    gate_w  = 0;
                    err_at  = -1;
                end
                if (cnt_en === 1'b1) gate_w++;
                if (bcd_start === 1'b1) begin
                    bs_cyc  = cyc;
                    have_bs = 1'b1;
                end
                if (have_bs && err === 1'b1 && err_at < 0) err_at = cyc - bs_cyc;
            end
        end
    end

    // BCD converter model: answers each bcd_start after done_dly cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (bcd_start === 1'b1 && done_dly >= 0) begin
                repeat (done_dly) @(negedge clk);
                bcd_done = 1'b1;
                @(negedge clk);
                bcd_done = 1'b0;
            end
        end
    end

    task automatic push_exp(input int g, input int tail, input int o, input int er,
                            input int rq, input int ea);
        exp_t e;
        e.g = g; e.lat = g + 2; e.tail = tail; e.ovf = o; e.err = er; e.rq = rq; e.err_at = ea;
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        push_exp(v.g, v.tail, v.ovf, v.err, int'(v.rng), v.err_at);
        range_sel = v.rng;
        done_dly  = v.dly;
        @(negedge clk) single = 1'b1;
        @(negedge clk) single = 1'b0;
        wait_sig(0, 10, "gate_start");
        for (int i = 0; i < 8; i++) begin
            if (i == v.ovf_at) cnt_ovf = 1'b1;
            if (i == 3 && v.toggle) range_sel = ~v.rng;
            if (i == 2 && v.extra) single = 1'b1;
            @(negedge clk);
            cnt_ovf = 1'b0;
            single  = 1'b0;
        end
        wait_sig(1, 20000, "measurement_end");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        bit seen;
        vecs[0] = '{2'd0,  5, -1, 1'b0, 1'b0, 10000, 26, 0, 0, -1};
        vecs[1] = '{2'd1,  5, -1, 1'b0, 1'b1,  1000, 26, 0, 0, -1};
        vecs[2] = '{2'd2,  5, -1, 1'b1, 1'b0,   100, 26, 0, 0, -1};
        vecs[3] = '{2'd3,  3, -1, 1'b0, 1'b0,    10, 24, 0, 0, -1};
        vecs[4] = '{2'd3,  1,  4, 1'b0, 1'b0,    10, 22, 1, 0, -1};
        vecs[5] = '{2'd3,  5, -1, 1'b0, 1'b0,    10, 26, 0, 0, -1};
        vecs[6] = '{2'd2, -1, -1, 1'b0, 1'b0,   100, 84, 0, 1, 64};
        vecs[7] = '{2'd3,  5, -1, 1'b0, 1'b0,    10, 26, 0, 0, -1};
        vecs[8] = '{2'd3,  0,  4, 1'b0, 1'b0,    10, 84, 1, 1, 64};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_a_p = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset mid-gate aborts; ovf/err/range_q are non-zero going in.
        range_sel = 2'd1;
        done_dly  = 5;
        @(negedge clk) single = 1'b1;
        @(negedge clk) single = 1'b0;
        wait_sig(0, 10, "reset_gate_start");
        repeat (20) @(negedge clk);
        rst_a_p = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid_gate");
        rst_a_p = 1'b0;
        repeat (5) @(negedge clk);
        check_idle_outputs("idle_after_reset");

        // Continuous mode, started with run and single together; run dropped in the third gate.
        base      = clr_total;
        range_sel = 2'd3;
        done_dly  = 5;
        for (int i = 0; i < 3; i++) push_exp(10, 26, 0, 0, 3, -1);
        @(negedge clk) begin run = 1'b1; single = 1'b1; end
        @(negedge clk) single = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (clr_total >= base + 3) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL run_third_clear: got %0d clears, required 3", clr_total - base);
        end
        @(negedge clk);
        run = 1'b0;
        wait_sig(1, 2000, "run_stop");
        repeat (60) @(negedge clk);
        check("clears_after_run_stop", clr_total - base, 3);

        check("scoreboard_left", sb.size(), 0);
        check("protocol_violations", proto_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
